// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory response block: access sizes and FSM states.
package dmem_pkg;

    localparam logic [1:0] SZ_WORD    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_BYTE    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: store byte-enable/data merge and load lane extract with sign/zero extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] old_word,
    output logic [31:0] new_word,
    output logic [31:0] load_data
);

    logic [3:0]  byte_en;
    logic [31:0] wdata_rep;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        byte_en   = 4'b0000;
        wdata_rep = wdata;
        case (size)
            SZ_WORD: byte_en = 4'b1111;
            SZ_HALF: begin
                byte_en   = lane[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            SZ_BYTE: begin
                byte_en   = 4'b0001 << lane;
                wdata_rep = {4{wdata[7:0]}};
            end
            default: byte_en = 4'b0000;
        endcase

        new_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                new_word[8*i +: 8] = wdata_rep[8*i +: 8];
            end
        end
    end

    // Half lane ignores lane[0]; alignment policy is decided by the caller.
    always_comb begin
        half_sel  = lane[1] ? old_word[31:16] : old_word[15:0];
        byte_sel  = 8'(old_word >> {lane, 3'b000});
        load_data = 32'h0;
        case (size)
            SZ_WORD: load_data = old_word;
            SZ_HALF: load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            SZ_BYTE: load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_mem_resp.sv
// Data memory with a fixed-latency valid/ready response path.
// Optional DMEM_ALIGN_CHECK_EN: misaligned half/word accesses respond with an error.
module data_mem_resp
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        write_q, write_d;
    logic        unsigned_q, unsigned_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_array [DEPTH_WORDS];

    logic [31:0]      acc_addr, acc_wdata, old_word, new_word, load_data;
    logic [1:0]       acc_size;
    logic             acc_write, acc_unsigned, acc_err, misaligned, enter_resp, mem_we;
    logic [IDX_W-1:0] acc_idx;

    // With zero wait cycles RESP is entered on the accept edge, so use the live request there.
    always_comb begin
        if (state_q == IDLE) begin
            acc_addr     = req_addr;
            acc_wdata    = req_wdata;
            acc_size     = req_size;
            acc_write    = req_write;
            acc_unsigned = req_unsigned;
        end else begin
            acc_addr     = addr_q;
            acc_wdata    = wdata_q;
            acc_size     = size_q;
            acc_write    = write_q;
            acc_unsigned = unsigned_q;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = ((acc_size == SZ_HALF) && acc_addr[0]) ||
                        ((acc_size == SZ_WORD) && (acc_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign acc_idx  = acc_addr[IDX_W+1:2];
    assign old_word = mem_array[acc_idx];
    assign acc_err  = (acc_size == SZ_ILLEGAL) || (|acc_addr[31:IDX_W+2]) || misaligned;

    dmem_lane_align u_lane_align (
        .size        (acc_size),
        .is_unsigned (acc_unsigned),
        .lane        (acc_addr[1:0]),
        .wdata       (acc_wdata),
        .old_word    (old_word),
        .new_word    (new_word),
        .load_data   (load_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        write_d    = write_q;
        unsigned_d = unsigned_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    size_d     = req_size;
                    write_d    = req_write;
                    unsigned_d = req_unsigned;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_resp) begin
            err_d   = acc_err;
            rdata_d = (acc_err || acc_write) ? 32'h0 : load_data;
        end
    end

    assign mem_we = enter_resp && acc_write && !acc_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            size_q     <= SZ_WORD;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            write_q    <= write_d;
            unsigned_q <= unsigned_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // Array contents survive reset; a reset before RESP leaves mem_we low, so nothing is written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_array[acc_idx] <= new_word;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words stored; power of two, minimum 4.
REQ-002 Parameter WAIT_CYCLES, default 2, extra wait cycles inserted before every response; range 0..15.
REQ-003 Clk  input  1  single clock for all state; all flops on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  the MEM stage presents an access.
REQ-006 req_ready  output  1  the block can accept an access.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 = word, 01 = half, 10 = byte, 11 = illegal.
REQ-009 req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data; the value sits in the low bits for half and byte stores.
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_ready  input  1  the consumer accepts the response.
REQ-014 resp_rdata  output  32  load result (extended); 0 for stores and errors.
REQ-015 resp_err  output  1  access faulted; no memory change.

Function
REQ-016 The FSM shall have the states IDLE, WAIT and RESP; req_ready shall be 1 only in IDLE.
REQ-017 An access is accepted on a rising edge where req_valid=1 and req_ready=1; req_addr, req_wdata, req_size, req_write and req_unsigned shall be registered at that edge.
REQ-018 On acceptance, the FSM goes IDLE->WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0, and IDLE->RESP if WAIT_CYCLES=0.
REQ-019 In WAIT the counter decrements each cycle, and the FSM goes to RESP on the edge where the counter equals 0; resp_valid is therefore seen WAIT_CYCLES+1 cycles after the accept cycle.
REQ-020 Stores commit to the array, and load data is captured into resp_rdata, on the edge entering RESP; both are done exactly once per access.
REQ-021 In RESP, resp_valid=1 and resp_rdata and resp_err stay stable until resp_ready=1; that edge returns to IDLE, with no same-cycle re-accept.
REQ-022 Storage is little-endian with word index = addr[log2(DEPTH_WORDS)+1:2].
REQ-023 A half access selects the lane given by addr[1], and a byte access selects the lane given by addr[1:0].
REQ-024 Half and byte stores update only the addressed lanes; all other bytes are preserved.
REQ-025 An address at or above 4*DEPTH_WORDS, or req_size=11, shall give resp_err=1, resp_rdata=0 and no write.
REQ-026 resp_valid shall never assert without a prior accepted request; a resp_ready held high in IDLE or WAIT shall be ignored.

Reset
REQ-027 While Reset=0, the state shall be IDLE, the counter 0, and req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-028 Reset asserted mid-access shall abort the access; a store that has not yet reached RESP shall not be written.
REQ-029 The memory array shall not be cleared by reset.

Configuration
REQ-030 With DMEM_ALIGN_CHECK_EN defined, a misaligned access (half with addr[0]=1, or word with addr[1:0]!=0) shall respond with resp_err=1, resp_rdata=0 and no write.
REQ-031 With DMEM_ALIGN_CHECK_EN undefined, the alignment bits beyond lane selection shall be ignored (word ignores addr[1:0], half ignores addr[0]), and only REQ-025 errors shall be raised.

Structure
REQ-032 Shared package dmem_pkg shall hold the req_size encodings (SZ_WORD, SZ_HALF, SZ_BYTE) and the state enumeration (IDLE, WAIT, RESP).
REQ-033 One combinational sub-module, dmem_lane_align, shall perform the store byte-enable/data merge and the load lane extract plus sign/zero extension; all sequencing stays in data_mem_resp.

Verification
REQ-034 With WAIT_CYCLES=2, word store 0xDEADBEEF to 0x10 then word load from 0x10 shall give resp_valid 3 cycles after each accept and rdata=0xDEADBEEF.
REQ-035 After REQ-034, byte store 0x7F to 0x11, then signed half load from 0x10, shall give rdata=0x00007FEF; a signed byte load from 0x13 shall give 0xFFFFFFDE, and the unsigned form shall give 0x000000DE.
REQ-036 With resp_ready held 0 for 5 cycles in RESP, resp_valid, resp_rdata and resp_err shall stay constant and req_ready=0 throughout, with one transfer when resp_ready rises.
REQ-037 A load from 4*DEPTH_WORDS, or an access with req_size=11, shall give resp_err=1 and rdata=0; a subsequent readback shall show memory unchanged.
REQ-038 Reset pulsed during WAIT of a word store of 0x12345678 to 0x20 shall leave the prior content of 0x20 intact, with all outputs at their reset values.
REQ-039 A word load from 0x22 shall give resp_err=1 with DMEM_ALIGN_CHECK_EN defined, and shall return word 0x20 with resp_err=0 with DMEM_ALIGN_CHECK_EN undefined.
